sreg_wb_arbiter: RTL and testbench

Writeback arbiter and pending-write scoreboard for the scalar register file. Shares the single register-file write port among `NUM_REQ` writeback sources (ALU, load unit, vector-to-scalar moves) using round-robin arbitration with valid/ready handshakes, and drives the port from registered outputs. Also tracks which architectural registers have an outstanding write, so decode can stall on RAW hazards. Sits between the execution units and the register file write port; its busy outputs feed the decode/issue stall logic.

---
 rtl/sreg_wb_arbiter.sv | 127 ++++++++++++
 tb/tb_sreg_wb_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sreg_wb_arbiter.sv
// Scalar register-file writeback arbiter with round-robin grant
// and a pending-write (RAW) scoreboard for decode stall logic.
module sreg_wb_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid_i,
    output logic [NUM_REQ-1:0]               req_ready_o,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_rd_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_rd_data_i,
    output logic [ADDR_WIDTH-1:0]            rd_addr_o,
    output logic [DATA_WIDTH-1:0]            rd_data_o,
    output logic                             reg_write_en_o,
    input  logic                             busy_set_i,
    input  logic [ADDR_WIDTH-1:0]            busy_set_addr_i,
    input  logic [ADDR_WIDTH-1:0]            rs1_addr_i,
    input  logic [ADDR_WIDTH-1:0]            rs2_addr_i,
    output logic                             rs1_busy_o,
    output logic                             rs2_busy_o,
    output logic [(1<<ADDR_WIDTH)-1:0]       busy_vec_o
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int NREG  = 1 << ADDR_WIDTH;

    logic [PTR_W-1:0]      r_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_wen;
    logic [NREG-1:0]       r_busy;

    logic [NUM_REQ-1:0]    w_grant;
    logic [PTR_W-1:0]      w_gidx;
    logic                  w_any;
    int                    w_idx;
    logic [PTR_W-1:0]      w_ptr_nxt;
    logic [ADDR_WIDTH-1:0] w_win_addr;
    logic [DATA_WIDTH-1:0] w_win_data;
    logic [NREG-1:0]       w_busy_nxt;

    // First valid requester at or after the pointer, wrapping.
    always_comb begin
        w_any  = 1'b0;
        w_gidx = '0;
        w_idx  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!w_any && req_valid_i[w_idx]) begin
                w_any  = 1'b1;
                w_gidx = PTR_W'(w_idx);
            end
        end
    end

    always_comb begin
        w_grant = '0;
        if (w_any) begin
            w_grant[w_gidx] = 1'b1;
        end
    end

    assign w_win_addr = req_rd_addr_i[w_gidx*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_win_data = req_rd_data_i[w_gidx*DATA_WIDTH +: DATA_WIDTH];

    assign w_ptr_nxt = (w_gidx == PTR_W'(NUM_REQ-1)) ? '0
                                                     : w_gidx + 1'b1;

    assign req_ready_o = rst ? '0 : w_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_any) begin
            r_ptr <= w_ptr_nxt;
        end
    end

    // rd=0 grants are consumed but never raise the write enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wen     <= 1'b0;
            r_rd_addr <= '0;
            r_rd_data <= '0;
        end else begin
            r_wen <= w_any && (w_win_addr != '0);
            if (w_any) begin
                r_rd_addr <= w_win_addr;
                r_rd_data <= w_win_data;
            end
        end
    end

    assign rd_addr_o      = r_rd_addr;
    assign rd_data_o      = r_rd_data;
    assign reg_write_en_o = r_wen;

    // Set is applied after clear so a same-cycle set wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_wen) begin
            w_busy_nxt[r_rd_addr] = 1'b0;
        end
        if (busy_set_i) begin
            w_busy_nxt[busy_set_addr_i] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign rs1_busy_o = r_busy[rs1_addr_i];
    assign rs2_busy_o = r_busy[rs2_addr_i];
    assign busy_vec_o = r_busy;

endmodule

// File: tb/tb_sreg_wb_arbiter.sv
// Directed bench for sreg_wb_arbiter: queued expected writes are
// checked by a monitor; grants and busy bits are checked inline.
module tb_sreg_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid_i;
    logic [2:0]  req_ready_o;
    logic [14:0] req_rd_addr_i;
    logic [95:0] req_rd_data_i;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic        reg_write_en_o;
    logic        busy_set_i;
    logic [4:0]  busy_set_addr_i;
    logic [4:0]  rs1_addr_i;
    logic [4:0]  rs2_addr_i;
    logic        rs1_busy_o;
    logic        rs2_busy_o;
    logic [31:0] busy_vec_o;

    always #5 clk = ~clk;

    sreg_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_rd_addr_i(req_rd_addr_i), .req_rd_data_i(req_rd_data_i),
        .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
        .reg_write_en_o(reg_write_en_o),
        .busy_set_i(busy_set_i), .busy_set_addr_i(busy_set_addr_i),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o),
        .busy_vec_o(busy_vec_o)
    );

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t expq[$];
    wr_t mon_e;
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every write the port presents must match the oldest expected one.
    always @(negedge clk) begin
        if (!rst && reg_write_en_o) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                         rd_addr_o, rd_data_o);
            end else begin
                mon_e = expq.pop_front();
                chk("wr_addr", 64'(rd_addr_o), 64'(mon_e.a));
                chk("wr_data", 64'(rd_data_o), 64'(mon_e.d));
            end
        end
    end

    task automatic set_req(input int i, input logic v,
                           input logic [4:0] a, input logic [31:0] d);
        req_valid_i[i]          = v;
        req_rd_addr_i[i*5 +: 5]  = a;
        req_rd_data_i[i*32 +: 32] = d;
    endtask

    task automatic all_valid();
        for (int i = 0; i < 3; i++) begin
            set_req(i, 1'b1, 5'(10 + i), 32'h100 + 32'(i));
        end
    endtask

    task automatic none_valid();
        req_valid_i = '0;
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        expq.push_back('{a: a, d: d});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int order[6] = '{0, 1, 2, 0, 1, 2};

    initial begin
        rst             = 1'b1;
        req_valid_i     = '0;
        req_rd_addr_i   = '0;
        req_rd_data_i   = '0;
        busy_set_i      = 1'b0;
        busy_set_addr_i = '0;
        rs1_addr_i      = '0;
        rs2_addr_i      = '0;

        // Reset state
        step();
        all_valid();
        #1 chk("ready_in_rst", 64'(req_ready_o), 64'(3'b000));
        none_valid();
        step();
        rst = 1'b0;
        #1;
        chk("rst_wen", 64'(reg_write_en_o), 64'd0);
        chk("rst_addr", 64'(rd_addr_o), 64'd0);
        chk("rst_data", 64'(rd_data_o), 64'd0);
        chk("rst_busy", 64'(busy_vec_o), 64'd0);

        // Single requester
        set_req(1, 1'b1, 5'd5, 32'hDEADBEEF);
        #1 chk("single_ready", 64'(req_ready_o), 64'(3'b010));
        push(5'd5, 32'hDEADBEEF);
        step();
        none_valid();
        chk("single_wen1", 64'(reg_write_en_o), 64'd1);
        step();
        chk("single_wen2", 64'(reg_write_en_o), 64'd0);

        // Round-robin under contention, from reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        all_valid();
        for (int k = 0; k < 6; k++) begin
            #1 chk("rr_grant", 64'(req_ready_o), 64'(3'b001 << order[k]));
            push(5'(10 + order[k]), 32'h100 + 32'(order[k]));
            step();
        end
        none_valid();
        step();

        // Pointer after a skipped requester (ptr is 0 here)
        set_req(2, 1'b1, 5'd12, 32'h0000_2222);
        #1 chk("skip_g2", 64'(req_ready_o), 64'(3'b100));
        push(5'd12, 32'h0000_2222);
        step();
        none_valid();
        set_req(0, 1'b1, 5'd13, 32'h0000_3333);
        #1 chk("skip_g0", 64'(req_ready_o), 64'(3'b001));
        push(5'd13, 32'h0000_3333);
        step();
        all_valid();
        #1 chk("skip_ptr1", 64'(req_ready_o), 64'(3'b010));
        push(5'd11, 32'h101);
        step();
        none_valid();
        step();

        // rd=0 request: accepted, no write, pointer advances
        set_req(0, 1'b1, 5'd0, 32'h55);
        #1 chk("rd0_ready", 64'(req_ready_o), 64'(3'b001));
        step();
        none_valid();
        chk("rd0_nowen", 64'(reg_write_en_o), 64'd0);
        all_valid();
        #1 chk("rd0_ptr1", 64'(req_ready_o), 64'(3'b010));
        push(5'd11, 32'h101);
        step();
        none_valid();
        step();

        // Scoreboard lifecycle
        busy_set_i      = 1'b1;
        busy_set_addr_i = 5'd7;
        step();
        busy_set_i = 1'b0;
        rs1_addr_i = 5'd7;
        rs2_addr_i = 5'd0;
        #1;
        chk("sb_set7", 64'(rs1_busy_o), 64'd1);
        chk("sb_rs2_x0", 64'(rs2_busy_o), 64'd0);
        set_req(0, 1'b1, 5'd7, 32'h77);
        #1 chk("sb_wr_ready", 64'(req_ready_o), 64'(3'b001));
        push(5'd7, 32'h77);
        step();
        none_valid();
        chk("sb_t1_busy", 64'(rs1_busy_o), 64'd1);
        step();
        chk("sb_t2_clear", 64'(rs1_busy_o), 64'd0);

        // Same-cycle set and clear of x7
        busy_set_i      = 1'b1;
        busy_set_addr_i = 5'd7;
        step();
        busy_set_i = 1'b0;
        set_req(0, 1'b1, 5'd7, 32'h78);
        push(5'd7, 32'h78);
        step();
        none_valid();
        busy_set_i      = 1'b1;
        busy_set_addr_i = 5'd7;
        step();
        busy_set_i = 1'b0;
        chk("sb_set_wins", 64'(rs1_busy_o), 64'd1);

        // Set on x0 is ignored
        busy_set_i      = 1'b1;
        busy_set_addr_i = 5'd0;
        step();
        busy_set_i = 1'b0;
        chk("sb_x0_bit", 64'(busy_vec_o[0]), 64'd0);
        chk("sb_vec", 64'(busy_vec_o), 64'(32'h0000_0080));

        // Reset mid-operation
        busy_set_i      = 1'b1;
        busy_set_addr_i = 5'd3;
        step();
        busy_set_i = 1'b0;
        chk("rm_vec", 64'(busy_vec_o), 64'(32'h0000_0088));
        set_req(0, 1'b1, 5'd9, 32'h99);
        step();
        none_valid();
        chk("rm_wen_pre", 64'(reg_write_en_o), 64'd1);
        chk("rm_addr_pre", 64'(rd_addr_o), 64'd9);
        #1 rst = 1'b1;
        all_valid();
        #1;
        chk("rm_wen", 64'(reg_write_en_o), 64'd0);
        chk("rm_addr", 64'(rd_addr_o), 64'd0);
        chk("rm_data", 64'(rd_data_o), 64'd0);
        chk("rm_busy", 64'(busy_vec_o), 64'd0);
        chk("rm_ready", 64'(req_ready_o), 64'(3'b000));
        step();
        rst = 1'b0;
        #1 chk("rm_first_g0", 64'(req_ready_o), 64'(3'b001));
        push(5'd10, 32'h100);
        step();
        none_valid();
        step();
        step();

        chk("queue_drained", 64'(expq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
